// File: rtl/reg_names.sv
// Shared RV32 register-name enum and EX operand-mux select encodings.
package reg_names;

  typedef enum logic [4:0] {
    zero, ra, sp, gp, tp, t0, t1, t2,
    s0, s1, a0, a1, a2, a3, a4, a5,
    a6, a7, s2, s3, s4, s5, s6, s7,
    s8, s9, s10, s11, t3, t4, t5, t6
  } regName_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/data_forwarding_fwd_select.sv
// Per-operand bypass select: MEM beats WB, x0 never forwarded, zero latency.
module fwd_select
  import reg_names::*;
(
  input  regName_t   rs_i,
  input  logic       mem_we_i,
  input  regName_t   mem_rd_i,
  input  logic       wb_we_i,
  input  regName_t   wb_rd_i,
  output logic [1:0] sel_o
);

  // An unresolved condition takes the else path, so the result stays within 00/01/10.
  always_comb begin
    sel_o = FWD_NONE;
    if (mem_we_i && (mem_rd_i != zero) && (mem_rd_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_we_i && (wb_rd_i != zero) && (wb_rd_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/data_forwarding.sv
// EX-stage bypass unit with saturating forwarding-event counters.
// Optional macro DF_ASSERT_EN compiles in simulation-only sanity assertions.
module data_forwarding
  import reg_names::*;
#(
  parameter int REG_SIZE  = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_regWrite,
  input  logic                 wb_regWrite,
  input  regName_t             mem_rd,
  input  regName_t             wb_rd,
  input  regName_t             ex_rs1,
  input  regName_t             ex_rs2,
  output logic [1:0]           df_mux1,
  output logic [1:0]           df_mux2,
  output logic [CNT_WIDTH-1:0] mem_fwd_cnt,
  output logic [CNT_WIDTH-1:0] wb_fwd_cnt
);

  if (REG_SIZE != $bits(regName_t)) begin : g_bad_reg_size
    $error("REG_SIZE must equal the width of regName_t");
  end

  fwd_select u_sel_rs1 (
    .rs_i     (ex_rs1),
    .mem_we_i (mem_regWrite),
    .mem_rd_i (mem_rd),
    .wb_we_i  (wb_regWrite),
    .wb_rd_i  (wb_rd),
    .sel_o    (df_mux1)
  );

  fwd_select u_sel_rs2 (
    .rs_i     (ex_rs2),
    .mem_we_i (mem_regWrite),
    .mem_rd_i (mem_rd),
    .wb_we_i  (wb_regWrite),
    .wb_rd_i  (wb_rd),
    .sel_o    (df_mux2)
  );

  logic [1:0]           mem_inc, wb_inc;
  logic [CNT_WIDTH:0]   mem_sum, wb_sum;
  logic [CNT_WIDTH-1:0] mem_fwd_cnt_d, mem_fwd_cnt_q;
  logic [CNT_WIDTH-1:0] wb_fwd_cnt_d, wb_fwd_cnt_q;

  assign mem_inc = {1'b0, df_mux1 == FWD_MEM} + {1'b0, df_mux2 == FWD_MEM};
  assign wb_inc  = {1'b0, df_mux1 == FWD_WB}  + {1'b0, df_mux2 == FWD_WB};

  // One extra sum bit catches the carry-out; any carry clamps to all-ones.
  always_comb begin
    mem_sum       = {1'b0, mem_fwd_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, mem_inc};
    wb_sum        = {1'b0, wb_fwd_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, wb_inc};
    mem_fwd_cnt_d = mem_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : mem_sum[CNT_WIDTH-1:0];
    wb_fwd_cnt_d  = wb_sum[CNT_WIDTH]  ? {CNT_WIDTH{1'b1}} : wb_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_fwd_cnt_q <= '0;
      wb_fwd_cnt_q  <= '0;
    end else begin
      mem_fwd_cnt_q <= mem_fwd_cnt_d;
      wb_fwd_cnt_q  <= wb_fwd_cnt_d;
    end
  end

  assign mem_fwd_cnt = mem_fwd_cnt_q;
  assign wb_fwd_cnt  = wb_fwd_cnt_q;

`ifdef DF_ASSERT_EN
  always @(posedge clk) begin
    assert (df_mux1 != 2'b11 && df_mux2 != 2'b11)
      else $error("illegal select: rs1=%s rs2=%s mem_rd=%s wb_rd=%s",
                  ex_rs1.name(), ex_rs2.name(), mem_rd.name(), wb_rd.name());
    assert (!((ex_rs1 == zero) && (df_mux1 != FWD_NONE)))
      else $error("forward selected for rs1=%s", ex_rs1.name());
    assert (!((ex_rs2 == zero) && (df_mux2 != FWD_NONE)))
      else $error("forward selected for rs2=%s", ex_rs2.name());
    if (!rst) begin
      assert (mem_fwd_cnt_d >= mem_fwd_cnt_q && wb_fwd_cnt_d >= wb_fwd_cnt_q)
        else $error("counter decrease: rs1=%s rs2=%s mem_rd=%s wb_rd=%s",
                    ex_rs1.name(), ex_rs2.name(), mem_rd.name(), wb_rd.name());
    end
  end
`endif

endmodule

// File: tb/tb_data_forwarding.sv
// Directed bench for data_forwarding plus a randomized priority-rule scoreboard.
module tb_data_forwarding;
  import reg_names::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_we, wb_we;
  regName_t   mem_rd_r, wb_rd_r, rs1_r, rs2_r;
  logic [1:0] mux1, mux2, mux1_s, mux2_s;
  logic [31:0] mem_cnt, wb_cnt;
  logic [3:0]  mem_cnt_s, wb_cnt_s;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_mem = 0;
  logic [31:0] exp_wb  = 0;
  logic [3:0]  exp_mem_s = 0;

  always #5 clk = ~clk;

  data_forwarding #(.REG_SIZE(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mem_regWrite(mem_we), .wb_regWrite(wb_we),
    .mem_rd(mem_rd_r), .wb_rd(wb_rd_r), .ex_rs1(rs1_r), .ex_rs2(rs2_r),
    .df_mux1(mux1), .df_mux2(mux2), .mem_fwd_cnt(mem_cnt), .wb_fwd_cnt(wb_cnt)
  );

  data_forwarding #(.REG_SIZE(5), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .mem_regWrite(mem_we), .wb_regWrite(wb_we),
    .mem_rd(mem_rd_r), .wb_rd(wb_rd_r), .ex_rs1(rs1_r), .ex_rs2(rs2_r),
    .df_mux1(mux1_s), .df_mux2(mux2_s), .mem_fwd_cnt(mem_cnt_s), .wb_fwd_cnt(wb_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] ref_sel(regName_t rs, logic mw, regName_t mrd,
                                         logic ww, regName_t wrd);
    logic hit_m, hit_w;
    hit_m = mw && (mrd == rs) && (rs != zero);
    hit_w = ww && (wrd == rs) && (rs != zero);
    if (hit_m) return 2'b01;
    if (hit_w) return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive(input regName_t r1, input regName_t r2, input regName_t mrd,
                       input logic mw, input regName_t wrd, input logic ww);
    rs1_r = r1; rs2_r = r2; mem_rd_r = mrd; mem_we = mw; wb_rd_r = wrd; wb_we = ww;
  endtask

  // Apply a vector, check selects, clock once, check counters against hand expectations.
  task automatic step(input string tag, input regName_t r1, input regName_t r2,
                      input regName_t mrd, input logic mw, input regName_t wrd,
                      input logic ww, input logic [1:0] e1, input logic [1:0] e2,
                      input int dmem, input int dwb);
    drive(r1, r2, mrd, mw, wrd, ww);
    #1;
    chk({tag, ".mux1"}, {30'd0, mux1}, {30'd0, e1});
    chk({tag, ".mux2"}, {30'd0, mux2}, {30'd0, e2});
    @(posedge clk);
    exp_mem = exp_mem + dmem;
    exp_wb  = exp_wb + dwb;
    @(negedge clk);
    chk({tag, ".mem_cnt"}, mem_cnt, exp_mem);
    chk({tag, ".wb_cnt"}, wb_cnt, exp_wb);
  endtask

  initial begin
    rst = 1'b1;
    drive(t1, a0, t1, 1'b1, zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset.mem_cnt", mem_cnt, 32'd0);
    chk("reset.wb_cnt", wb_cnt, 32'd0);
    chk("reset.mux1_live", {30'd0, mux1}, 32'd1);
    chk("reset.mux2_live", {30'd0, mux2}, 32'd0);
    rst = 1'b0;

    step("mem_fwd_rs1", t1, a0, t1, 1'b1, zero, 1'b0, 2'b01, 2'b00, 1, 0);
    step("mem_prio",    t2, t2, t2, 1'b1, t2,   1'b1, 2'b01, 2'b01, 2, 0);
    step("mem_suppr",   a1, s1, s1, 1'b0, s1,   1'b1, 2'b00, 2'b10, 0, 1);
    step("x0_never",    zero, zero, zero, 1'b1, zero, 1'b1, 2'b00, 2'b00, 0, 0);
    step("split",       s2, s3, s3, 1'b1, s2,   1'b1, 2'b10, 2'b01, 1, 1);
    step("wb_both",     t6, t6, t5, 1'b1, t6,   1'b1, 2'b10, 2'b10, 0, 2);
    step("no_hit",      a7, s11, a6, 1'b1, t3,  1'b1, 2'b00, 2'b00, 0, 0);

    // One reset edge while forwarding is active.
    rst = 1'b1;
    drive(t2, t2, t2, 1'b1, t2, 1'b1);
    #1;
    chk("rst_active.mux1", {30'd0, mux1}, 32'd1);
    chk("rst_active.mux2", {30'd0, mux2}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_mem = 0;
    exp_wb  = 0;
    chk("rst_edge.mem_cnt", mem_cnt, 32'd0);
    chk("rst_edge.wb_cnt", wb_cnt, 32'd0);
    chk("rst_edge.mem_cnt_s", {28'd0, mem_cnt_s}, 32'd0);

    // Two MEM forwards per cycle: 4-bit counter must clamp at 15.
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      exp_mem = exp_mem + 2;
      exp_mem_s = (2 * k >= 15) ? 4'd15 : 4'(2 * k);
      @(negedge clk);
      chk($sformatf("sat%0d.mem_cnt_s", k), {28'd0, mem_cnt_s}, {28'd0, exp_mem_s});
    end
    chk("sat.wb_cnt_s", {28'd0, wb_cnt_s}, 32'd0);
    chk("sat.mem_cnt", mem_cnt, exp_mem);

    // Randomized vectors against the priority-rule scoreboard.
    for (int i = 0; i < 150; i++) begin
      logic [1:0] e1, e2;
      drive(regName_t'($urandom_range(0, 31)), regName_t'($urandom_range(0, 31)),
            regName_t'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            regName_t'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) rs2_r = rs1_r;
      if ($urandom_range(0, 2) == 0) mem_rd_r = rs1_r;
      if ($urandom_range(0, 2) == 0) wb_rd_r = rs2_r;
      #1;
      e1 = ref_sel(rs1_r, mem_we, mem_rd_r, wb_we, wb_rd_r);
      e2 = ref_sel(rs2_r, mem_we, mem_rd_r, wb_we, wb_rd_r);
      chk($sformatf("rnd%0d.mux1", i), {30'd0, mux1}, {30'd0, e1});
      chk($sformatf("rnd%0d.mux2", i), {30'd0, mux2}, {30'd0, e2});
      @(posedge clk);
      exp_mem = exp_mem + 32'(e1 == 2'b01) + 32'(e2 == 2'b01);
      exp_wb  = exp_wb + 32'(e1 == 2'b10) + 32'(e2 == 2'b10);
      @(negedge clk);
    end
    chk("rnd.mem_cnt", mem_cnt, exp_mem);
    chk("rnd.wb_cnt", wb_cnt, exp_wb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_forwarding.md
Name: data_forwarding

Overview:
- Data-forwarding (bypass) unit for the 5-stage RV32I pipeline; sits beside the EX stage.
- Compares the EX-stage source registers against the destination registers of the instructions in MEM and WB.
- Drives the two EX operand-mux selects, so ALU operands take the newest in-flight value instead of the stale register-file value.
- Also keeps clocked forwarding-event counters used for performance monitoring.

Parameters:
- REG_SIZE, 5, width of a register index; must equal the width of regName_t.
- CNT_WIDTH, 32, width of each forwarding-event counter.

Ports:
- clk  input  1  system clock; counters update on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- mem_regWrite  input  1  the instruction in MEM writes a register.
- wb_regWrite  input  1  the instruction in WB writes a register.
- mem_rd  input  regName_t (5)  destination register of the instruction in MEM.
- wb_rd  input  regName_t (5)  destination register of the instruction in WB.
- ex_rs1  input  regName_t (5)  source register 1 of the instruction in EX.
- ex_rs2  input  regName_t (5)  source register 2 of the instruction in EX.
- df_mux1  output  2  operand-1 select.
- df_mux2  output  2  operand-2 select.
- mem_fwd_cnt  output  CNT_WIDTH  accumulated operands forwarded from MEM.
- wb_fwd_cnt  output  CNT_WIDTH  accumulated operands forwarded from WB.

Behaviour:
- Select encoding (both outputs):
  - 2'b00 = register-file value (no forward).
  - 2'b01 = forward the MEM-stage (EX/MEM) ALU result.
  - 2'b10 = forward the WB-stage write-back value.
  - 2'b11 is never driven.
- df_mux1 and df_mux2 are purely combinational, with zero latency. They are independent of clk and rst, and are valid during reset.
- Rule for operand n (rs = ex_rs1 or ex_rs2), first match wins:
  1. mem_regWrite && mem_rd != zero && mem_rd == rs -> 01.
  2. wb_regWrite && wb_rd != zero && wb_rd == rs -> 10.
  3. Otherwise -> 00.
- MEM takes priority over WB when both match, because MEM holds the younger value.
- Register x0 (zero) is never forwarded, regardless of regWrite.
- regWrite=0 suppresses any match from that stage.
- rs1 == rs2 is legal; both selects then carry the same code.
- Counters, on each rising clk edge:
  - If rst=1, both counters load 0.
  - Otherwise mem_fwd_cnt += (df_mux1==01) + (df_mux2==01), and wb_fwd_cnt += (df_mux1==10) + (df_mux2==10). Each increment is 0..2 per cycle.
  - Counters saturate at all-ones and never wrap; an increment of 2 at max-1 yields max.
- Any X/unknown on inputs must not produce 2'b11; an unresolved comparison falls to 00.

Optional Feature:
- Macro DF_ASSERT_EN.
- When defined, simulation-only immediate assertions are compiled in:
  - df_mux1 and df_mux2 are never 2'b11.
  - No forward is ever selected for a source equal to zero.
  - Outside reset, neither counter ever decreases.
- A violation reports $error with the offending register names.
- When undefined, no assertion code is compiled; RTL behaviour is identical.

Decomposition:
- regName_t (5-bit enum of RV32 ABI register names: zero, ra, sp, gp, tp, t0-t6, s0-s11, a0-a7) lives in the existing shared package reg_names. The block imports it.
- The select encodings (FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) are exported as localparams/enum in the same package, so the EX operand muxes share them.
- One sub-module is natural: fwd_select. It is instantiated twice (rs1, rs2), takes rs, mem_rd/regWrite and wb_rd/regWrite, and returns the 2-bit select.
- Counters stay in the top module.

Test Plan:
- ex_rs1=t1, ex_rs2=a0, mem_rd=t1, mem_regWrite=1, wb_regWrite=0 -> df_mux1=01, df_mux2=00.
- mem_rd=t2, wb_rd=t2, both regWrite=1, ex_rs1=t2, ex_rs2=t2 -> df_mux1=df_mux2=01 (MEM priority); next edge mem_fwd_cnt +2.
- wb_rd=s1, wb_regWrite=1, mem_regWrite=0, mem_rd=s1, ex_rs2=s1 -> df_mux2=10 (mem suppressed by regWrite=0).
- mem_rd=zero, wb_rd=zero, both regWrite=1, ex_rs1=ex_rs2=zero -> both selects 00; counters unchanged.
- rst=1 for one edge with forwarding active -> both counters 0 after edge; selects still follow inputs during reset.
- CNT_WIDTH=4, hold two MEM forwards per cycle for 10 cycles -> mem_fwd_cnt saturates at 15, no wrap.
- Randomized: 150 cycles of random regNames/regWrite, checked against the priority rule via a scoreboard.
